// File: rtl/usb_host_txn_engine.sv
// rtl/usb_host_txn_engine.sv - host-side USB IN/OUT transaction sequencer with toggle tracking and retry
module usb_host_txn_engine #(
   parameter int DATA_W      = 64,
   parameter int NUM_EP      = 16,
   parameter int TIMEOUT_CYC = 255,
   parameter int MAX_RETRY   = 8
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              start,
   input  logic              is_in,
   input  logic [6:0]        addr,
   input  logic [3:0]        endp,
   input  logic [DATA_W-1:0] data_from_host,
   input  logic              clear_toggle,
   input  logic [3:0]        clear_ep,
   input  logic              pkt_sent,
   input  logic              pkt_received,
   input  logic              crc_correct,
   input  logic [3:0]        rx_pid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              encode,
   output logic              kill,
   output logic              decode,
   output logic [3:0]        tx_pid,
   output logic [6:0]        tx_addr,
   output logic [3:0]        tx_endp,
   output logic [DATA_W-1:0] tx_data,
   output logic [4:0]        crc_type,
   output logic              busy,
   output logic              success,
   output logic              failure,
   output logic [1:0]        err_code,
   output logic [DATA_W-1:0] data_to_host
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_TOKEN     = 3'd1;
   localparam logic [2:0] S_TOK_WAIT  = 3'd2;
   localparam logic [2:0] S_DATA_WAIT = 3'd3;
   localparam logic [2:0] S_RX        = 3'd4;
   localparam logic [2:0] S_HS_WAIT   = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int CW = $clog2(MAX_RETRY + 1);

   logic [2:0]        state_q, state_d;
   logic              is_in_q, is_in_d;
   logic [6:0]        addr_q, addr_d;
   logic [3:0]        endp_q, endp_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NUM_EP-1:0] toggle_q, toggle_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CW-1:0]     cnt_corrupt_q, cnt_corrupt_d;
   logic [CW-1:0]     cnt_tmo_q, cnt_tmo_d;
   logic              hs_ok_q, hs_ok_d;
   logic              done_ok_q, done_ok_d;
   logic              encode_q, encode_d, kill_q, kill_d, decode_q, decode_d;
   logic [3:0]        tx_pid_q, tx_pid_d;
   logic [6:0]        tx_addr_q, tx_addr_d;
   logic [3:0]        tx_endp_q, tx_endp_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [4:0]        crc_type_q, crc_type_d;
   logic              busy_q, busy_d, success_q, success_d, failure_q, failure_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] dth_q, dth_d;
   logic              tog_cur, flip, ev_corrupt, ev_tmo;

   // current endpoint toggle; endpoints beyond NUM_EP read as DATA0
   always_comb begin
      tog_cur = 1'b0;
      for (int i = 0; i < NUM_EP; i++)
         if (endp_q == 4'(i)) tog_cur = toggle_q[i];
   end

   // transaction sequencing, retry accounting and registered output values
   always_comb begin
      state_d = state_q;           is_in_d = is_in_q;       addr_d = addr_q;
      endp_d = endp_q;             data_d = data_q;         timer_d = timer_q;
      cnt_corrupt_d = cnt_corrupt_q; cnt_tmo_d = cnt_tmo_q; hs_ok_d = hs_ok_q;
      done_ok_d = done_ok_q;       tx_pid_d = tx_pid_q;     tx_addr_d = tx_addr_q;
      tx_endp_d = tx_endp_q;       tx_data_d = tx_data_q;   crc_type_d = crc_type_q;
      err_d = err_q;               dth_d = dth_q;
      encode_d = 1'b0; kill_d = 1'b0; decode_d = 1'b0; success_d = 1'b0; failure_d = 1'b0;
      flip = 1'b0; ev_corrupt = 1'b0; ev_tmo = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            is_in_d = is_in; addr_d = addr; endp_d = endp; data_d = data_from_host;
            cnt_corrupt_d = '0; cnt_tmo_d = '0; err_d = 2'd0;
            state_d = S_TOKEN;
         end
         S_TOKEN: begin
            tx_pid_d = is_in_q ? PID_IN : PID_OUT;
            tx_addr_d = addr_q; tx_endp_d = endp_q; crc_type_d = 5'd5;
            encode_d = 1'b1; kill_d = 1'b1;
            state_d = S_TOK_WAIT;
         end
         S_TOK_WAIT: if (pkt_sent) begin
            if (is_in_q) begin
               decode_d = 1'b1; timer_d = '0; state_d = S_RX;
            end else begin
               tx_pid_d = tog_cur ? PID_DATA1 : PID_DATA0;
               tx_data_d = data_q; crc_type_d = 5'd16;
               encode_d = 1'b1; kill_d = 1'b1;
               state_d = S_DATA_WAIT;
            end
         end
         S_DATA_WAIT: if (pkt_sent) begin
            decode_d = 1'b1; timer_d = '0; state_d = S_RX;
         end
         S_RX: begin
            timer_d = timer_q + TW'(1);
            if (pkt_received) begin
               if (!crc_correct) ev_corrupt = 1'b1;
               else if (rx_pid == PID_STALL) begin
                  done_ok_d = 1'b0; err_d = 2'd3; state_d = S_DONE;
               end else if (is_in_q && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
                  // a repeated packet is still ACKed so the device advances, but its payload is dropped
                  tx_pid_d = PID_ACK; crc_type_d = 5'd0; encode_d = 1'b1; kill_d = 1'b1;
                  state_d = S_HS_WAIT;
                  hs_ok_d = ((rx_pid == PID_DATA1) == tog_cur);
                  if ((rx_pid == PID_DATA1) == tog_cur) begin
                     dth_d = rx_data; flip = 1'b1;
                  end
               end else if (!is_in_q && rx_pid == PID_ACK) begin
                  flip = 1'b1; done_ok_d = 1'b1; state_d = S_DONE;
               end else if (rx_pid == PID_NAK) ev_tmo = 1'b1;
               else ev_corrupt = 1'b1;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) ev_tmo = 1'b1;
         end
         S_HS_WAIT: if (pkt_sent) begin
            if (hs_ok_q) begin
               done_ok_d = 1'b1; state_d = S_DONE;
            end else ev_corrupt = 1'b1;
         end
         S_DONE: begin
            success_d = done_ok_q; failure_d = !done_ok_q; state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (ev_corrupt) begin
         if (cnt_corrupt_q + CW'(1) == CW'(MAX_RETRY)) begin
            done_ok_d = 1'b0; err_d = 2'd1; state_d = S_DONE;
         end else begin
            cnt_corrupt_d = cnt_corrupt_q + CW'(1); state_d = S_TOKEN;
         end
      end
      if (ev_tmo) begin
         if (cnt_tmo_q + CW'(1) == CW'(MAX_RETRY)) begin
            done_ok_d = 1'b0; err_d = 2'd2; state_d = S_DONE;
         end else begin
            cnt_tmo_d = cnt_tmo_q + CW'(1); state_d = S_TOKEN;
         end
      end
      // busy drops together with the completion pulse
      busy_d = (state_d != S_IDLE);
   end

   // toggle table: a clear request beats a same-cycle flip
   always_comb begin
      toggle_d = toggle_q;
      for (int i = 0; i < NUM_EP; i++) begin
         if (flip && endp_q == 4'(i)) toggle_d[i] = ~toggle_q[i];
         if (clear_toggle && clear_ep == 4'(i)) toggle_d[i] = 1'b0;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE; is_in_q <= 1'b0; addr_q <= '0; endp_q <= '0; data_q <= '0;
         toggle_q <= '0; timer_q <= '0; cnt_corrupt_q <= '0; cnt_tmo_q <= '0;
         hs_ok_q <= 1'b0; done_ok_q <= 1'b0; encode_q <= 1'b0; kill_q <= 1'b0;
         decode_q <= 1'b0; tx_pid_q <= '0; tx_addr_q <= '0; tx_endp_q <= '0;
         tx_data_q <= '0; crc_type_q <= '0; busy_q <= 1'b0; success_q <= 1'b0;
         failure_q <= 1'b0; err_q <= '0; dth_q <= '0;
      end else begin
         state_q <= state_d; is_in_q <= is_in_d; addr_q <= addr_d; endp_q <= endp_d;
         data_q <= data_d; toggle_q <= toggle_d; timer_q <= timer_d;
         cnt_corrupt_q <= cnt_corrupt_d; cnt_tmo_q <= cnt_tmo_d; hs_ok_q <= hs_ok_d;
         done_ok_q <= done_ok_d; encode_q <= encode_d; kill_q <= kill_d;
         decode_q <= decode_d; tx_pid_q <= tx_pid_d; tx_addr_q <= tx_addr_d;
         tx_endp_q <= tx_endp_d; tx_data_q <= tx_data_d; crc_type_q <= crc_type_d;
         busy_q <= busy_d; success_q <= success_d; failure_q <= failure_d;
         err_q <= err_d; dth_q <= dth_d;
      end
   end

   assign encode = encode_q;       assign kill = kill_q;           assign decode = decode_q;
   assign tx_pid = tx_pid_q;       assign tx_addr = tx_addr_q;     assign tx_endp = tx_endp_q;
   assign tx_data = tx_data_q;     assign crc_type = crc_type_q;   assign busy = busy_q;
   assign success = success_q;     assign failure = failure_q;     assign err_code = err_q;
   assign data_to_host = dth_q;

endmodule

// File: tb/tb_usb_host_txn_engine.sv
// tb/tb_usb_host_txn_engine.sv - directed self-checking bench for usb_host_txn_engine
module tb_usb_host_txn_engine;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        start = 1'b0, is_in = 1'b0;
   logic [6:0]  addr = '0;
   logic [3:0]  endp = '0;
   logic [63:0] data_from_host = '0;
   logic        clear_toggle = 1'b0;
   logic [3:0]  clear_ep = '0;
   logic        pkt_sent = 1'b0, pkt_received = 1'b0, crc_correct = 1'b0;
   logic [3:0]  rx_pid = '0;
   logic [63:0] rx_data = '0;
   logic        encode, kill, decode, busy, success, failure;
   logic [3:0]  tx_pid, tx_endp;
   logic [6:0]  tx_addr;
   logic [63:0] tx_data, data_to_host;
   logic [4:0]  crc_type;
   logic [1:0]  err_code;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   usb_host_txn_engine dut (
      .clk(clk), .rst_b(rst_b), .start(start), .is_in(is_in), .addr(addr), .endp(endp),
      .data_from_host(data_from_host), .clear_toggle(clear_toggle), .clear_ep(clear_ep),
      .pkt_sent(pkt_sent), .pkt_received(pkt_received), .crc_correct(crc_correct),
      .rx_pid(rx_pid), .rx_data(rx_data), .encode(encode), .kill(kill), .decode(decode),
      .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data),
      .crc_type(crc_type), .busy(busy), .success(success), .failure(failure),
      .err_code(err_code), .data_to_host(data_to_host)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_txn(input logic in_, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d);
      is_in = in_; addr = a; endp = e; data_from_host = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_done();
      pkt_sent = 1'b1;
      @(negedge clk);
      pkt_sent = 1'b0;
   endtask

   task automatic rx_pkt(input logic [3:0] pid, input logic [63:0] d, input logic ok);
      pkt_received = 1'b1; rx_pid = pid; rx_data = d; crc_correct = ok;
      @(negedge clk);
      pkt_received = 1'b0; crc_correct = 1'b0;
   endtask

   task automatic wait_encode(input string tag);
      int n = 0;
      while (!encode && n < 400) begin @(negedge clk); n++; end
      check({tag, "_encode"}, 64'(encode), 64'd1);
   endtask

   task automatic wait_decode(input string tag);
      int n = 0;
      while (!decode && n < 20) begin @(negedge clk); n++; end
      check({tag, "_decode"}, 64'(decode), 64'd1);
   endtask

   task automatic wait_done(input string tag, input logic exp_ok);
      int n = 0;
      while (!success && !failure && n < 400) begin @(negedge clk); n++; end
      check({tag, "_success"}, 64'(success), 64'(exp_ok));
      check({tag, "_failure"}, 64'(failure), 64'(!exp_ok));
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic token_step(input string tag, input logic [3:0] pid, input logic [6:0] a,
                             input logic [3:0] e);
      wait_encode(tag);
      check({tag, "_pid"}, 64'(tx_pid), 64'(pid));
      check({tag, "_addr"}, 64'(tx_addr), 64'(a));
      check({tag, "_endp"}, 64'(tx_endp), 64'(e));
      check({tag, "_crc"}, 64'(crc_type), 64'd5);
      check({tag, "_kill"}, 64'(kill), 64'd1);
      send_done();
   endtask

   task automatic out_attempt(input string tag, input logic [3:0] dpid, input logic [63:0] d);
      token_step({tag, "_tok"}, 4'b0001, 7'd3, 4'd2);
      wait_encode({tag, "_dat"});
      check({tag, "_dpid"}, 64'(tx_pid), 64'(dpid));
      check({tag, "_dcrc"}, 64'(crc_type), 64'd16);
      check({tag, "_ddata"}, tx_data, d);
      send_done();
      wait_decode(tag);
   endtask

   initial begin
      int last;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_encode", 64'(encode), 64'd0);
      check("rst_tx_pid", 64'(tx_pid), 64'd0);
      check("rst_dth", data_to_host, 64'd0);
      check("rst_toggles", 64'(dut.toggle_q), 64'd0);
      rst_b = 1'b1;
      @(negedge clk);

      // IN ep4 receiving DATA0 with good CRC
      start_txn(1'b1, 7'd5, 4'd4, 64'd0);
      token_step("t1_tok", 4'b1001, 7'd5, 4'd4);
      wait_decode("t1");
      rx_pkt(4'b0011, 64'hDEADBEEF_CAFEF00D, 1'b1);
      wait_encode("t1_ack");
      check("t1_ack_pid", 64'(tx_pid), 64'h2);
      check("t1_ack_crc", 64'(crc_type), 64'd0);
      send_done();
      wait_done("t1", 1'b1);
      check("t1_dth", data_to_host, 64'hDEADBEEF_CAFEF00D);
      check("t1_err", 64'(err_code), 64'd0);
      check("t1_toggles", 64'(dut.toggle_q), 64'h10);

      // IN ep4 answered with STALL
      start_txn(1'b1, 7'd5, 4'd4, 64'd0);
      token_step("t5_tok", 4'b1001, 7'd5, 4'd4);
      wait_decode("t5");
      rx_pkt(4'b1110, 64'd0, 1'b1);
      wait_done("t5", 1'b0);
      check("t5_err", 64'(err_code), 64'd3);
      check("t5_toggles", 64'(dut.toggle_q), 64'h10);

      // IN ep1 with no device response; a start while busy must be ignored
      start_txn(1'b1, 7'd6, 4'd1, 64'd0);
      last = 0;
      for (int k = 0; k < 8; k++) begin
         wait_encode("t2_tok");
         check("t2_pid", 64'(tx_pid), 64'h9);
         check("t2_addr", 64'(tx_addr), 64'd6);
         if (k > 0) check("t2_gap", 64'(cyc - last), 64'd257);
         last = cyc;
         send_done();
         if (k == 0) start_txn(1'b0, 7'd9, 4'd7, 64'd0);
      end
      wait_done("t2", 1'b0);
      check("t2_err", 64'(err_code), 64'd2);

      // OUT ep2: NAK, NAK, ACK
      start_txn(1'b0, 7'd3, 4'd2, 64'h01234567_89ABCDEF);
      out_attempt("t3a", 4'b0011, 64'h01234567_89ABCDEF);
      rx_pkt(4'b1010, 64'd0, 1'b1);
      out_attempt("t3b", 4'b0011, 64'h01234567_89ABCDEF);
      rx_pkt(4'b1010, 64'd0, 1'b1);
      out_attempt("t3c", 4'b0011, 64'h01234567_89ABCDEF);
      rx_pkt(4'b0010, 64'd0, 1'b1);
      wait_done("t3", 1'b1);
      check("t3_toggles", 64'(dut.toggle_q), 64'h14);

      // next OUT ep2 carries DATA1
      start_txn(1'b0, 7'd3, 4'd2, 64'h55AA);
      out_attempt("t3d", 4'b1011, 64'h55AA);
      rx_pkt(4'b0010, 64'd0, 1'b1);
      wait_done("t3d", 1'b1);
      check("t3d_toggles", 64'(dut.toggle_q), 64'h10);

      // OUT ep2 DATA0 ACKed while clear_toggle ep2 fires in the same cycle
      start_txn(1'b0, 7'd3, 4'd2, 64'h77);
      out_attempt("t6", 4'b0011, 64'h77);
      clear_toggle = 1'b1; clear_ep = 4'd2;
      rx_pkt(4'b0010, 64'd0, 1'b1);
      clear_toggle = 1'b0;
      wait_done("t6", 1'b1);
      check("t6_toggles", 64'(dut.toggle_q), 64'h10);

      // IN ep4 expecting DATA1 gets DATA0 first, then DATA1
      start_txn(1'b1, 7'd5, 4'd4, 64'd0);
      token_step("t4_tok1", 4'b1001, 7'd5, 4'd4);
      wait_decode("t4a");
      rx_pkt(4'b0011, 64'h11111111_11111111, 1'b1);
      wait_encode("t4_ack1");
      check("t4_ack1_pid", 64'(tx_pid), 64'h2);
      send_done();
      token_step("t4_tok2", 4'b1001, 7'd5, 4'd4);
      check("t4_dth_kept", data_to_host, 64'hDEADBEEF_CAFEF00D);
      wait_decode("t4b");
      rx_pkt(4'b1011, 64'h22222222_33333333, 1'b1);
      wait_encode("t4_ack2");
      check("t4_ack2_pid", 64'(tx_pid), 64'h2);
      send_done();
      wait_done("t4", 1'b1);
      check("t4_dth", data_to_host, 64'h22222222_33333333);
      check("t4_toggles", 64'(dut.toggle_q), 64'h0);

      // reset asserted while waiting in RX
      start_txn(1'b1, 7'd8, 4'd0, 64'd0);
      token_step("t7_tok", 4'b1001, 7'd8, 4'd0);
      wait_decode("t7");
      rst_b = 1'b0;
      #1;
      check("t7_busy", 64'(busy), 64'd0);
      check("t7_tx_pid", 64'(tx_pid), 64'd0);
      check("t7_tx_addr", 64'(tx_addr), 64'd0);
      check("t7_dth", data_to_host, 64'd0);
      check("t7_decode", 64'(decode), 64'd0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb_host_txn_engine.md
Name: usb_host_txn_engine

Overview:
Parametrised host-side USB transaction engine, successor to the fixed-address single-endpoint protocol FSM. It sequences IN and OUT transactions (token, data, handshake) toward the packet encoder/decoder datastream. Adds runtime address/endpoint selection, per-endpoint DATA0/DATA1 toggle tracking, device NAK/STALL handling, spec-correct retry (token re-issue) and configurable timeout/retry limits. Sits between the host command interface and the encode/decode datastream blocks.

Parameters:
DATA_W, 64, data payload width in bits
NUM_EP, 16, number of endpoints with tracked toggle bits (endp < NUM_EP)
TIMEOUT_CYC, 255, clk cycles waited in RX before a timeout event
MAX_RETRY, 8, failing attempts per counter class before failure (>=1)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
start  in  1  launch transaction; sampled only in IDLE
is_in  in  1  1=IN, 0=OUT; captured with start
addr  in  7  device address; captured with start
endp  in  4  endpoint; captured with start
data_from_host  in  DATA_W  OUT payload; captured with start
clear_toggle  in  1  reset toggle of endpoint clear_ep to DATA0
clear_ep  in  4  endpoint for clear_toggle
pkt_sent  in  1  encoder finished current packet
pkt_received  in  1  decoder delivered a packet
crc_correct  in  1  valid with pkt_received
rx_pid  in  4  received PID
rx_data  in  DATA_W  received payload
encode  out  1  one-cycle pulse: transmit tx_*
kill  out  1  one-cycle pulse with encode: abort prior stream
decode  out  1  one-cycle pulse: arm decoder
tx_pid  out  4  PID to send
tx_addr  out  7  address field
tx_endp  out  4  endpoint field
tx_data  out  DATA_W  data field
crc_type  out  5  5=CRC5 token, 16=CRC16 data, 0=handshake
busy  out  1  high whenever state != IDLE
success  out  1  one-cycle completion pulse
failure  out  1  one-cycle completion pulse
err_code  out  2  0 none, 1 corrupt limit, 2 timeout/NAK limit, 3 STALL; held until next start
data_to_host  out  DATA_W  last accepted IN payload; held

Behaviour:
- Reset: state IDLE; all outputs 0; all toggle bits 0; counters 0.
- PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- All outputs registered. encode/kill/decode pulse exactly one cycle.
- States: IDLE, TOKEN, TOK_WAIT, DATA_WAIT, RX, HS_WAIT, DONE.
- IDLE: start -> capture is_in/addr/endp/data, clear counters and err_code, -> TOKEN.
- TOKEN: tx_pid=IN or OUT, tx_addr/endp captured, crc_type=5, encode+kill pulse, -> TOK_WAIT.
- TOK_WAIT on pkt_sent: IN -> RX with decode pulse; OUT -> emit DATA0/DATA1 per toggle[endp], tx_data=captured, crc_type=16, encode+kill, -> DATA_WAIT.
- DATA_WAIT on pkt_sent -> RX, decode pulse.
- RX: timer cleared on entry, increments per cycle. Priority order:
  1. pkt_received & !crc_correct -> corrupt event.
  2. STALL -> DONE, failure, err 3.
  3. IN: DATAx matching toggle -> latch data_to_host, flip toggle, send ACK (crc_type 0), -> HS_WAIT; on pkt_sent -> DONE success.
  4. IN: DATAx mismatched toggle -> send ACK, discard, counted as corrupt event, retry after HS_WAIT.
  5. OUT: ACK -> flip toggle, DONE success.
  6. NAK -> timeout-class event.
  7. Any other PID -> corrupt event.
  8. Timer == TIMEOUT_CYC-1 with no packet -> timeout event.
- Event handling: counter+1 == MAX_RETRY -> DONE, failure, err 1 (corrupt) or 2 (timeout/NAK); else increment and -> TOKEN (full transaction re-issue, same toggle).
- DONE: success or failure pulse for one cycle, -> IDLE. busy falls the same cycle.
- clear_toggle applies in any state; on same-cycle conflict with a toggle flip for the same endpoint, clear wins.
- endp >= NUM_EP: toggle reads 0, never updated.
- start while busy is ignored. Reset mid-transaction: immediate return to IDLE, toggles cleared.

Test Plan:
- IN addr 5 ep 4, device returns DATA0 0xDEADBEEF_CAFEF00D CRC ok -> IN token, ACK sent, data_to_host matches, success, toggle[4]=1.
- IN with no response -> exactly MAX_RETRY=8 IN tokens at TIMEOUT_CYC spacing, then failure, err 2.
- OUT ep 2: NAK, NAK, ACK -> 3 OUT+DATA0 pairs, success, toggle[2]=1; next OUT sends DATA1.
- IN after toggle=1 receives DATA0 -> ACK sent, data_to_host unchanged, IN re-issued; DATA1 then accepted.
- IN receives STALL -> failure, err 3 within 1 cycle of DONE, toggles unchanged.
- clear_toggle ep 2 same cycle as OUT ACK on ep 2 -> toggle[2]=0; rst_b low in RX -> busy 0, all outputs 0.
